block_lock_fsm: RTL

BLOCK_LOCK_FSM -- requirements
Module: block_lock_fsm

---
 rtl/pcs_lock_pkg.sv | 17 +
 rtl/block_lock_fsm_if.sv | 25 ++
 rtl/sat_counter.sv | 23 ++
 rtl/block_lock_fsm.sv | 134 +++++++++++++
 4 files changed

// File: rtl/pcs_lock_pkg.sv
// Shared types and helpers for the 64b/66b block-lock state machine:
// state encoding, sync-header width and the header validity test.
package pcs_lock_pkg;

    localparam int HDR_WIDTH = 2;

    typedef enum logic {
        ST_TEST_SH   = 1'b0,
        ST_SLIP_WAIT = 1'b1
    } lock_state_e;

    // A sync header is legal only when its two bits differ (01 or 10).
    function automatic logic hdr_is_valid(input logic [HDR_WIDTH-1:0] hdr);
        return ^hdr;
    endfunction

endpackage

// File: rtl/block_lock_fsm_if.sv
// Sync-header stream from the gearbox into the block-lock FSM, and the
// slip / lock indications flowing back.
interface block_lock_fsm_if;
    import pcs_lock_pkg::*;

    logic                 i_hdr_valid;
    logic [HDR_WIDTH-1:0] i_hdr;
    logic                 o_slip;
    logic                 o_block_lock;

    modport master (
        output i_hdr_valid,
        output i_hdr,
        input  o_slip,
        input  o_block_lock
    );

    modport slave (
        input  i_hdr_valid,
        input  i_hdr,
        output o_slip,
        output o_block_lock
    );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/block_lock_fsm.sv
// 64b/66b block-lock search: tests sync headers in fixed windows and slips the
// gearbox on bad headers. Define BLOCK_LOCK_STATS_EN to add slip/lock-loss counters.
module block_lock_fsm
    import pcs_lock_pkg::*;
#(
    parameter int SH_CNT_MAX  = 64,
    parameter int INVALID_MAX = 16,
    parameter int SLIP_WAIT   = 4,
    parameter int STAT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    block_lock_fsm_if.slave       bus
`ifdef BLOCK_LOCK_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] o_stat_slips,
    output logic [STAT_WIDTH-1:0] o_stat_lock_loss
`endif
);

    localparam int SH_W   = $clog2(SH_CNT_MAX + 1);
    localparam int INV_W  = $clog2(INVALID_MAX + 1);
    localparam int WAIT_W = (SLIP_WAIT > 0) ? $clog2(SLIP_WAIT + 1) : 1;

    if (SH_CNT_MAX < 2) begin : g_bad_sh_cnt_max
        $error("block_lock_fsm: SH_CNT_MAX must be at least 2");
    end
    if ((INVALID_MAX < 1) || (INVALID_MAX > SH_CNT_MAX)) begin : g_bad_invalid_max
        $error("block_lock_fsm: INVALID_MAX must lie in 1..SH_CNT_MAX");
    end
    if (SLIP_WAIT < 0) begin : g_bad_slip_wait
        $error("block_lock_fsm: SLIP_WAIT must not be negative");
    end
    if (STAT_WIDTH < 1) begin : g_bad_stat_width
        $error("block_lock_fsm: STAT_WIDTH must be at least 1");
    end

    lock_state_e       r_state;
    logic [SH_W-1:0]   r_sh_cnt;
    logic [INV_W-1:0]  r_inv_cnt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_slip;
    logic              r_block_lock;

    logic              w_hdr_take;
    logic              w_hdr_bad;
    logic [SH_W-1:0]   w_sh_next;
    logic [INV_W-1:0]  w_inv_next;
    logic              w_slip_evt;
    logic              w_window_done;

    // While unlocked r_inv_cnt stays 0, and while locked it never exceeds
    // INVALID_MAX-1, so the +1 below cannot overflow its width.
    assign w_hdr_take    = (r_state == ST_TEST_SH) && bus.i_hdr_valid;
    assign w_hdr_bad     = !hdr_is_valid(bus.i_hdr);
    assign w_sh_next     = r_sh_cnt + SH_W'(1);
    assign w_inv_next    = r_inv_cnt + INV_W'(w_hdr_bad);
    assign w_slip_evt    = w_hdr_take && w_hdr_bad &&
                           (!r_block_lock || (w_inv_next == INV_W'(INVALID_MAX)));
    assign w_window_done = w_hdr_take && !w_slip_evt &&
                           (w_sh_next == SH_W'(SH_CNT_MAX));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= ST_TEST_SH;
            r_sh_cnt     <= '0;
            r_inv_cnt    <= '0;
            r_wait_cnt   <= '0;
            r_slip       <= 1'b0;
            r_block_lock <= 1'b0;
        end else begin
            r_slip <= 1'b0;
            case (r_state)
                ST_TEST_SH: begin
                    if (w_slip_evt) begin
                        r_slip       <= 1'b1;
                        r_block_lock <= 1'b0;
                        r_sh_cnt     <= '0;
                        r_inv_cnt    <= '0;
                        r_wait_cnt   <= WAIT_W'(SLIP_WAIT);
                        r_state      <= ST_SLIP_WAIT;
                    end else if (w_window_done) begin
                        r_sh_cnt  <= '0;
                        r_inv_cnt <= '0;
                        if (w_inv_next == '0) begin
                            r_block_lock <= 1'b1;
                        end
                    end else if (w_hdr_take) begin
                        r_sh_cnt  <= w_sh_next;
                        r_inv_cnt <= w_inv_next;
                    end
                end
                // The slip cycle itself is blanked, then SLIP_WAIT more cycles.
                ST_SLIP_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_state <= ST_TEST_SH;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
                    end
                end
                default: r_state <= ST_TEST_SH;
            endcase
        end
    end

    assign bus.o_slip       = r_slip;
    assign bus.o_block_lock = r_block_lock;

`ifdef BLOCK_LOCK_STATS_EN
    logic w_loss_evt;

    // Lock can only drop through a slip taken while locked.
    assign w_loss_evt = w_slip_evt && r_block_lock;

    sat_counter #(
        .WIDTH (STAT_WIDTH)
    ) u_stat_slips (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_inc     (w_slip_evt),
        .o_count   (o_stat_slips)
    );

    sat_counter #(
        .WIDTH (STAT_WIDTH)
    ) u_stat_lock_loss (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_inc     (w_loss_evt),
        .o_count   (o_stat_lock_loss)
    );
`endif

endmodule
